// File: rtl/wb2uart_if.sv
// Wishbone classic bus bundle between a local master and the wb2uart slave.
// Signal names keep the slave-side suffixes so they read the same as the
// slave's port list.
interface wb2uart_if;
  logic        cyc_i;
  logic        stb_i;
  logic        we_i;
  logic [22:0] adr_i;
  logic [7:0]  dat_i;
  logic [7:0]  dat_o;
  logic        ack_o;
  logic        err_o;

  modport master (
    output cyc_i, stb_i, we_i, adr_i, dat_i,
    input  dat_o, ack_o, err_o
  );

  modport slave (
    input  cyc_i, stb_i, we_i, adr_i, dat_i,
    output dat_o, ack_o, err_o
  );
endinterface

// File: rtl/wb2uart.sv
// wb2uart: Wishbone classic slave that turns each bus cycle into a 4-byte
// UART command frame for the UART-to-Wishbone bridge, then waits for the
// bridge's 1-byte reply and terminates the cycle with ack_o (good stop bit)
// or err_o (framing error).
// Optional feature macro: WB2UART_TIMEOUT_EN adds a response timeout that
// ends the cycle with err_o and dat_o=8'hFF when the bridge stays silent.
module wb2uart #(
  parameter int CLKS_PER_BIT = 16
`ifdef WB2UART_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 4096
`endif
) (
  input  logic     clk_i,
  input  logic     rst_i,
  wb2uart_if.slave wb,
  output logic     uart_txd,
  input  logic     uart_rxd
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

`ifdef WB2UART_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
`endif

  typedef enum logic [3:0] {
    IDLE, TX_START, TX_DATA, TX_STOP,
    RX_WAIT, RX_START, RX_DATA, RX_STOP, DONE
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [1:0]    byte_q, byte_d;
  logic [7:0]    rx_shift_q, rx_shift_d;
  logic [7:0]    rdat_q, rdat_d;
  logic          resp_err_q, resp_err_d;
  logic          txd_q, txd_d;
  logic [7:0]    tx_byte;

  logic          we_q;
  logic [22:0]   adr_q;
  logic [7:0]    wdat_q;

  logic          rxd_meta, rxd_sync, rxd_prev;
  logic          req, capture, bit_end;

`ifdef WB2UART_TIMEOUT_EN
  logic [TW-1:0] to_q;
`endif

  assign req     = wb.cyc_i & wb.stb_i;
  assign bit_end = (baud_q == BIT_LAST);

  // Bring the bridge's TX line into the clock domain; idle level is high.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rxd_meta <= 1'b1;
      rxd_sync <= 1'b1;
      rxd_prev <= 1'b1;
    end else begin
      rxd_meta <= uart_rxd;
      rxd_sync <= rxd_meta;
      rxd_prev <= rxd_sync;
    end
  end

  // Snapshot the request once; later bus changes must not disturb the frame.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      we_q   <= 1'b0;
      adr_q  <= '0;
      wdat_q <= '0;
    end else if (capture) begin
      we_q   <= wb.we_i;
      adr_q  <= wb.adr_i;
      wdat_q <= wb.we_i ? wb.dat_i : 8'h00;
    end
  end

`ifdef WB2UART_TIMEOUT_EN
  // Silence counter: zero outside RX_WAIT, so every entry starts from zero.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                  to_q <= '0;
    else if (state_q != RX_WAIT) to_q <= '0;
    else                        to_q <= to_q + 1'b1;
  end
`endif

  // State, bit timing, and response registers; txd is registered so it never glitches.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      baud_q     <= '0;
      bit_q      <= '0;
      byte_q     <= '0;
      rx_shift_q <= '0;
      rdat_q     <= '0;
      resp_err_q <= 1'b0;
      txd_q      <= 1'b1;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      byte_q     <= byte_d;
      rx_shift_q <= rx_shift_d;
      rdat_q     <= rdat_d;
      resp_err_q <= resp_err_d;
      txd_q      <= txd_d;
    end
  end

  // Next-state logic: transmit four bytes back-to-back, then receive one reply byte.
  always_comb begin
    state_d    = state_q;
    baud_d     = baud_q;
    bit_d      = bit_q;
    byte_d     = byte_q;
    rx_shift_d = rx_shift_q;
    rdat_d     = rdat_q;
    resp_err_d = resp_err_q;
    capture    = 1'b0;

    case (state_q)
      IDLE: begin
        if (req) begin
          capture = 1'b1;
          state_d = TX_START;
          baud_d  = '0;
          bit_d   = '0;
          byte_d  = '0;
        end
      end
      TX_START: begin
        if (bit_end) begin
          state_d = TX_DATA;
          baud_d  = '0;
          bit_d   = '0;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      TX_DATA: begin
        if (bit_end) begin
          baud_d = '0;
          bit_d  = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = TX_STOP;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      TX_STOP: begin
        if (bit_end) begin
          baud_d  = '0;
          byte_d  = byte_q + 2'd1;
          state_d = (byte_q == 2'd3) ? RX_WAIT : TX_START;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      RX_WAIT: begin
        if (rxd_prev && !rxd_sync) begin
          state_d = RX_START;
          baud_d  = '0;
        end
`ifdef WB2UART_TIMEOUT_EN
        else if (to_q == TO_LAST) begin
          state_d    = DONE;
          rdat_d     = 8'hFF;
          resp_err_d = 1'b1;
        end
`endif
      end
      RX_START: begin
        if (baud_q == HALF_LAST) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = rxd_sync ? RX_WAIT : RX_DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (bit_end) begin
          baud_d     = '0;
          rx_shift_d = {rxd_sync, rx_shift_q[7:1]};
          bit_d      = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = RX_STOP;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (bit_end) begin
          baud_d     = '0;
          rdat_d     = rx_shift_q;
          resp_err_d = !rxd_sync;
          state_d    = DONE;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Line level for the upcoming cycle, taken from where the transmitter is headed.
  always_comb begin
    case (byte_d)
      2'd0:    tx_byte = {we_q, adr_q[22:16]};
      2'd1:    tx_byte = adr_q[15:8];
      2'd2:    tx_byte = adr_q[7:0];
      default: tx_byte = wdat_q;
    endcase
    txd_d = 1'b1;
    if (state_d == TX_START)     txd_d = 1'b0;
    else if (state_d == TX_DATA) txd_d = tx_byte[bit_d];
  end

  assign uart_txd = txd_q;
  assign wb.dat_o = rdat_q;
  assign wb.ack_o = (state_q == DONE) && !resp_err_q && req;
  assign wb.err_o = (state_q == DONE) &&  resp_err_q && req;

endmodule

// File: tb/tb_wb2uart.sv
// Self-checking bench for wb2uart: table of bus requests with expected UART
// frames and replies, plus hand-written reset, dropped-cycle and timeout cases.
module tb_wb2uart;
  localparam int CPB = 16;
`ifdef WB2UART_TIMEOUT_EN
  localparam int TO_CYCLES = 100;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic txd;
  logic rxd = 1'b1;

  wb2uart_if bus();

  int checks = 0;
  int errors = 0;
  int cyc_n = 0;
  int cap_cyc = 0;
  int pulse_cnt = 0;
  int last_pulse_cyc = 0;

  typedef struct {
    logic [7:0] data;
    logic       first;
  } tx_exp_t;

  typedef struct {
    logic       is_err;
    logic [7:0] data;
  } rsp_exp_t;

  typedef struct {
    logic        we;
    logic [22:0] adr;
    logic [7:0]  dat;
    logic [31:0] frame;
    logic [7:0]  reply;
    logic        reply_stop;
    logic        glitch;
    logic        exp_err;
    logic [7:0]  exp_dat;
  } vec_t;

  tx_exp_t  tx_q[$];
  rsp_exp_t rsp_q[$];
  vec_t     vecs[4];

`ifdef WB2UART_TIMEOUT_EN
  wb2uart #(.CLKS_PER_BIT(CPB), .TIMEOUT_CYCLES(TO_CYCLES)) dut (
`else
  wb2uart #(.CLKS_PER_BIT(CPB)) dut (
`endif
    .clk_i   (clk),
    .rst_i   (rst),
    .wb      (bus),
    .uart_txd(txd),
    .uart_rxd(rxd)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic releaseBus();
    bus.cyc_i = 1'b0;
    bus.stb_i = 1'b0;
    bus.we_i  = 1'b0;
    bus.adr_i = '0;
    bus.dat_i = '0;
  endtask

  task automatic startRequest(input logic we, input logic [22:0] adr,
                              input logic [7:0] dat, input logic [31:0] frame);
    tx_exp_t e;
    @(negedge clk);
    bus.cyc_i = 1'b1;
    bus.stb_i = 1'b1;
    bus.we_i  = we;
    bus.adr_i = adr;
    bus.dat_i = dat;
    for (int i = 0; i < 4; i++) begin
      e.data  = frame[31 - 8*i -: 8];
      e.first = (i == 0);
      tx_q.push_back(e);
    end
    @(posedge clk);
    #1 cap_cyc = cyc_n;
  endtask

  task automatic waitTxDone();
    int n = 0;
    while (tx_q.size() != 0 && n < 50*CPB) begin
      @(negedge clk);
      #1 n++;
    end
    checkOutput("tx_frame_complete", tx_q.size(), 0);
    tx_q.delete();
    repeat (CPB) @(negedge clk);
  endtask

  task automatic waitResp(input int budget);
    int n = 0;
    while (rsp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      #1 n++;
    end
    checkOutput("rsp_complete", rsp_q.size(), 0);
    rsp_q.delete();
  endtask

  task automatic sendReply(input logic [7:0] b, input logic stop);
    @(negedge clk);
    rxd = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (CPB) @(negedge clk);
    end
    rxd = stop;
    repeat (CPB) @(negedge clk);
    rxd = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic applyStimulus(input vec_t v);
    rsp_exp_t r;
    startRequest(v.we, v.adr, v.dat, v.frame);
    r.is_err = v.exp_err;
    r.data   = v.exp_dat;
    rsp_q.push_back(r);
    waitTxDone();
    if (v.glitch) begin
      rxd = 1'b0;
      repeat (4) @(negedge clk);
      rxd = 1'b1;
      repeat (3*CPB) @(negedge clk);
    end
    fork
      sendReply(v.reply, v.reply_stop);
      begin
        waitResp(12*CPB);
        releaseBus();
      end
    join
    repeat (4) @(negedge clk);
    checkOutput("dat_hold", bus.dat_o, v.exp_dat);
  endtask

  // Decode the command stream on txd and score each byte and its timing.
  initial begin : tx_monitor
    logic    prev;
    logic    busy;
    int      cnt;
    int      idx;
    int      start_c;
    int      last_start;
    logic [7:0] sh;
    tx_exp_t e;
    prev = 1'b1; busy = 1'b0; cnt = 0; idx = 0;
    start_c = 0; last_start = 0; sh = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        busy = 1'b0;
        prev = 1'b1;
      end else begin
        if (!busy) begin
          if (prev && !txd) begin
            busy    = 1'b1;
            cnt     = 0;
            start_c = cyc_n;
          end
        end else begin
          cnt++;
          if (cnt == CPB/2) begin
            checkOutput("tx_start_bit", txd, 0);
          end else if (cnt > CPB/2 && ((cnt - CPB/2) % CPB) == 0) begin
            idx = (cnt - CPB/2) / CPB;
            if (idx <= 8) begin
              sh[idx-1] = txd;
            end else begin
              busy = 1'b0;
              checkOutput("tx_stop_bit", txd, 1);
              if (tx_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL tx_unexpected: got byte %02h, required no byte", sh);
              end else begin
                e = tx_q.pop_front();
                checkOutput("tx_byte", sh, e.data);
                if (e.first) checkOutput("tx_first_latency", start_c - cap_cyc, 0);
                else         checkOutput("tx_byte_spacing", start_c - last_start, 10*CPB);
              end
              last_start = start_c;
            end
          end
        end
        prev = txd;
      end
    end
  end

  // Score every bus termination pulse against the expected response queue.
  initial begin : pulse_monitor
    rsp_exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && (bus.ack_o || bus.err_o)) begin
        pulse_cnt++;
        last_pulse_cyc = cyc_n;
        checkOutput("ack_err_exclusive", bus.ack_o & bus.err_o, 0);
        if (rsp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_pulse: got ack=%0b err=%0b, required none", bus.ack_o, bus.err_o);
        end else begin
          e = rsp_q.pop_front();
          checkOutput("rsp_err", bus.err_o, e.is_err);
          checkOutput("rsp_ack", bus.ack_o, !e.is_err);
          checkOutput("rsp_dat", bus.dat_o, e.data);
        end
      end
    end
  end

  initial begin : watchdog
    #(60000 * 10);
    $display("[TB] FAIL watchdog: simulation exceeded cycle budget, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    int p0;
    vecs[0] = '{we:1'b1, adr:23'h12_3456, dat:8'hA5, frame:32'h9234_56A5,
                reply:8'h00, reply_stop:1'b1, glitch:1'b0, exp_err:1'b0, exp_dat:8'h00};
    vecs[1] = '{we:1'b0, adr:23'h7F_FFFF, dat:8'h99, frame:32'h7FFF_FF00,
                reply:8'h3C, reply_stop:1'b1, glitch:1'b0, exp_err:1'b0, exp_dat:8'h3C};
    vecs[2] = '{we:1'b1, adr:23'h05_0F0F, dat:8'h5A, frame:32'h850F_0F5A,
                reply:8'h55, reply_stop:1'b0, glitch:1'b0, exp_err:1'b1, exp_dat:8'h55};
    vecs[3] = '{we:1'b0, adr:23'h40_00AA, dat:8'h11, frame:32'h4000_AA00,
                reply:8'hC3, reply_stop:1'b1, glitch:1'b1, exp_err:1'b0, exp_dat:8'hC3};

    releaseBus();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset_txd", txd, 1);
    checkOutput("reset_ack", bus.ack_o, 0);
    checkOutput("reset_err", bus.err_o, 0);
    checkOutput("reset_dat", bus.dat_o, 8'h00);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      $display("[TB] vector %0d: we=%0b adr=%06h", i, vecs[i].we, vecs[i].adr);
      applyStimulus(vecs[i]);
    end

    $display("[TB] cycle dropped after capture");
    p0 = pulse_cnt;
    startRequest(1'b0, 23'h00_0010, 8'h00, 32'h0000_1000);
    @(negedge clk);
    bus.cyc_i = 1'b0;
    bus.stb_i = 1'b0;
    bus.we_i  = 1'b1;
    bus.adr_i = 23'h7F_0000;
    bus.dat_i = 8'hEE;
    waitTxDone();
    sendReply(8'h77, 1'b1);
    repeat (CPB) @(negedge clk);
    releaseBus();
    checkOutput("drop_dat", bus.dat_o, 8'h77);
    checkOutput("drop_no_pulse", pulse_cnt - p0, 0);

    $display("[TB] link still in sync after dropped cycle");
    applyStimulus(vecs[1]);

    $display("[TB] reset during second command byte");
    p0 = pulse_cnt;
    startRequest(1'b1, 23'h12_3456, 8'hA5, 32'h9234_56A5);
    repeat (10*CPB + 6) @(negedge clk);
    checkOutput("pre_reset_txd", txd, 0);
    rst = 1'b1;
    #1;
    checkOutput("reset_txd_async", txd, 1);
    tx_q.delete();
    releaseBus();
    repeat (4) @(negedge clk);
    checkOutput("midframe_reset_ack", bus.ack_o, 0);
    checkOutput("midframe_reset_err", bus.err_o, 0);
    checkOutput("midframe_reset_dat", bus.dat_o, 8'h00);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("reset_no_pulse", pulse_cnt - p0, 0);
    applyStimulus(vecs[0]);

`ifdef WB2UART_TIMEOUT_EN
    begin
      rsp_exp_t r;
      $display("[TB] response timeout");
      startRequest(1'b0, 23'h00_0001, 8'h00, 32'h0000_0100);
      r.is_err = 1'b1;
      r.data   = 8'hFF;
      rsp_q.push_back(r);
      waitTxDone();
      waitResp(4*TO_CYCLES);
      releaseBus();
      checkOutput("timeout_latency", last_pulse_cyc - cap_cyc, 40*CPB + TO_CYCLES);
      repeat (4) @(negedge clk);
      checkOutput("timeout_dat", bus.dat_o, 8'hFF);
    end
`endif

    repeat (4) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
